// File: rtl/vga_pkg.sv
// vga_pkg: shared video timing defaults and arbiter state encoding.
// Used by vga_sync and vga_frame_arbiter.
package vga_pkg;

  localparam int CD_DEF = 12;
  localparam int HD_DEF = 640;
  localparam int VD_DEF = 480;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    SOF    = 2'd1,
    STREAM = 2'd2
  } arb_state_t;

  // Active pixels in one frame.
  function automatic int frame_px(input int hd, input int vd);
    return hd * vd;
  endfunction

endpackage

// File: rtl/vga_frame_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin / fixed-priority picker.
// Pointer state lives in the parent; this block only searches.
module rr_arbiter #(
  parameter int NSRC = 4,
  parameter int IW   = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_prio,
  output logic [NSRC-1:0] o_gnt_oh,
  output logic [IW-1:0]   o_gnt_idx,
  output logic            o_any
);

  logic [IW:0] w_base;
  logic [IW:0] w_sum;
  logic [IW-1:0] w_idx;

  // Scan requests starting at the pointer (or 0 in priority mode).
  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_base    = i_prio ? '0 : {1'b0, i_ptr};
    w_sum     = '0;
    w_idx     = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_sum = w_base + (IW+1)'(i);
      if (w_sum >= (IW+1)'(NSRC))
        w_sum = w_sum - (IW+1)'(NSRC);
      w_idx = w_sum[IW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any           = 1'b1;
        o_gnt_idx       = w_idx;
        o_gnt_oh[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_frame_arbiter.sv
// vga_frame_arbiter: grants one pixel source per frame and feeds
// its stream, with start flag and underflow fill, to vga_sync.
module vga_frame_arbiter
  import vga_pkg::*;
#(
  parameter int          CD   = CD_DEF,
  parameter int          NSRC = 4,
  parameter int          HD   = HD_DEF,
  parameter int          VD   = VD_DEF,
  parameter logic [CD-1:0] FILL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSRC*CD-1:0]       src_data,
  input  logic [NSRC-1:0]          src_valid,
  output logic [NSRC-1:0]          src_ready,
  input  logic [NSRC-1:0]          src_req,
  input  logic                     prio_mode,
  input  logic                     force_en,
  input  logic [$clog2(NSRC)-1:0]  force_sel,
  output logic [CD:0]              vga_so_data,
  output logic                     vga_so_valid,
  input  logic                     vga_so_ready,
  output logic                     grant_vld,
  output logic [$clog2(NSRC)-1:0]  grant_idx,
  output logic                     frame_done,
  output logic [15:0]              underflow_cnt
);

  localparam int IW  = $clog2(NSRC);
  localparam int NPX = frame_px(HD, VD);
  localparam int CW  = $clog2(NPX + 1);

  arb_state_t      r_state;
  logic            r_grant_vld;
  logic [IW-1:0]   r_grant_idx;
  logic [NSRC-1:0] r_grant_oh;
  logic [IW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_uf_cnt;
  logic            r_frame_done;

  logic [NSRC-1:0] w_arb_oh;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_any;

  logic            w_force_ok;
  logic            w_nxt_vld;
  logic [IW-1:0]   w_nxt_idx;
  logic [NSRC-1:0] w_nxt_oh;
  logic [IW-1:0]   w_ptr_nxt;

  logic            w_act;
  logic            w_consume;
  logic            w_last;
  logic            w_g_valid;
  logic [CD-1:0]   w_g_data;
  logic [CD-1:0]   w_pix;
  logic            w_uf;

  rr_arbiter #(
    .NSRC (NSRC),
    .IW   (IW)
  ) u_rr (
    .i_req     (src_req),
    .i_ptr     (r_rr_ptr),
    .i_prio    (prio_mode),
    .o_gnt_oh  (w_arb_oh),
    .o_gnt_idx (w_arb_idx),
    .o_any     (w_arb_any)
  );

  // Candidate grant for the next frame; force overrides arbitration.
  always_comb begin
    w_force_ok = ({1'b0, force_sel} < (IW+1)'(NSRC));
    w_nxt_vld  = w_arb_any;
    w_nxt_idx  = w_arb_idx;
    w_nxt_oh   = w_arb_oh;
    if (force_en) begin
      w_nxt_vld = w_force_ok;
      w_nxt_idx = force_sel;
      w_nxt_oh  = w_force_ok ? (NSRC'(1) << force_sel) : '0;
    end
  end

  // Pointer moves to the slot after the source that just finished.
  always_comb begin
    w_ptr_nxt = '0;
    if (r_grant_idx != IW'(NSRC - 1))
      w_ptr_nxt = r_grant_idx + IW'(1);
  end

  // Pixel mux: granted source when it has data, otherwise fill.
  always_comb begin
    w_act     = (r_state != ARB);
    w_consume = w_act & vga_so_ready;
    w_last    = (r_cnt == CW'(NPX - 1));
    w_g_valid = r_grant_vld & |(src_valid & r_grant_oh);
    w_g_data  = src_data[int'(r_grant_idx)*CD +: CD];
    w_pix     = w_g_valid ? w_g_data : FILL;
    w_uf      = w_consume & r_grant_vld & ~w_g_valid;
    vga_so_valid = w_act;
    vga_so_data  = w_act ? {w_pix, r_state == SOF}
                         : {FILL, 1'b0};
    src_ready = r_grant_oh &
                {NSRC{w_consume & r_grant_vld}};
  end

  // Frame FSM: latch grant in ARB, count consumed pixels to frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ARB;
      r_grant_vld  <= 1'b0;
      r_grant_idx  <= '0;
      r_grant_oh   <= '0;
      r_rr_ptr     <= '0;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        ARB: begin
          r_grant_vld <= w_nxt_vld;
          r_grant_idx <= w_nxt_idx;
          r_grant_oh  <= w_nxt_oh;
          r_cnt       <= '0;
          r_state     <= SOF;
        end
        SOF, STREAM: begin
          if (w_consume) begin
            if (w_last) begin
              r_cnt        <= '0;
              r_state      <= ARB;
              r_frame_done <= 1'b1;
              if (r_grant_vld)
                r_rr_ptr <= w_ptr_nxt;
            end else begin
              r_cnt   <= r_cnt + CW'(1);
              r_state <= STREAM;
            end
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  // Saturating count of fill pixels sent on behalf of a granted source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_uf_cnt <= '0;
    else if (w_uf && r_uf_cnt != 16'hFFFF)
      r_uf_cnt <= r_uf_cnt + 16'd1;
  end

  assign grant_vld     = r_grant_vld;
  assign grant_idx     = r_grant_idx;
  assign frame_done    = r_frame_done;
  assign underflow_cnt = r_uf_cnt;

endmodule
